// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI mode-0 responder.
// Defaults for the transmit filler byte and the minimum synchronizer depth.
package spi_slave_pkg;

    localparam logic [7:0] SPI_FILL_DEFAULT = 8'hFF;
    localparam int         SPI_SYNC_MIN     = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

    // Clamp a requested synchronizer depth to the supported minimum.
    function automatic int sync_depth(input int requested);
        return (requested < SPI_SYNC_MIN) ? SPI_SYNC_MIN : requested;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchronizer with a selectable reset value.
// The output is the last flop of a DEPTH-long shift chain.
module spi_sync #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic iClk,
    input  logic iRstN,
    input  logic iD,
    output logic oQ
);

    logic [DEPTH-1:0] r_q;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_q <= {DEPTH{RST_VAL}};
        end else begin
            r_q <= {r_q[DEPTH-2:0], iD};
        end
    end

    assign oQ = r_q[DEPTH-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 (CPOL=0, CPHA=0) byte responder, MSB first, oversampled in the iClk domain.
// Transmit bytes come from a one-entry holding register; FILL is sent when it is empty.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter logic [7:0] FILL = SPI_FILL_DEFAULT,
    parameter int         SYNC = 2
) (
    input  logic       iClk,
    input  logic       iRstN,
    input  logic       iSck,
    input  logic       iCsN,
    input  logic       iMosi,
    output logic       oMiso,
    output logic       oMisoEn,
    input  logic [7:0] iData,
    input  logic       iLoad,
    output logic       oTaken,
    output logic [7:0] oData,
    output logic       oAvail,
    output logic       oUnder,
    output logic       oBusy
);

    localparam int SYNC_EFF = sync_depth(SYNC);
    localparam int FW       = $clog2(SYNC_EFF + 1);

    logic w_sck_s;
    logic w_csn_s;
    logic w_mosi_s;

    spi_sync #(.DEPTH(SYNC_EFF), .RST_VAL(1'b0)) u_sync_sck (
        .iClk(iClk), .iRstN(iRstN), .iD(iSck), .oQ(w_sck_s)
    );
    spi_sync #(.DEPTH(SYNC_EFF), .RST_VAL(1'b1)) u_sync_csn (
        .iClk(iClk), .iRstN(iRstN), .iD(iCsN), .oQ(w_csn_s)
    );
    spi_sync #(.DEPTH(SYNC_EFF), .RST_VAL(1'b1)) u_sync_mosi (
        .iClk(iClk), .iRstN(iRstN), .iD(iMosi), .oQ(w_mosi_s)
    );

    logic          r_sck_d;
    logic          r_csn_d;
    logic [FW-1:0] r_flush;
    logic          r_armed;

    spi_state_e r_state;
    logic [7:0] r_tx;
    logic       r_tx_new;
    logic [6:0] r_rx;
    logic [2:0] r_bit_cnt;
    logic       r_miso;
    logic [7:0] r_data;
    logic       r_avail;

    logic [7:0] r_hold;
    logic       r_hold_full;
    logic       r_taken;
    logic       r_under;

    // Selection is only armed once the chain holds real pin samples and CS_n was seen high,
    // so a CS_n already low when reset releases cannot start a transfer.
    logic w_flushed;
    assign w_flushed = (r_flush == FW'(SYNC_EFF));

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_sck_d <= 1'b0;
            r_csn_d <= 1'b1;
            r_flush <= '0;
            r_armed <= 1'b0;
        end else begin
            r_sck_d <= w_sck_s;
            r_csn_d <= w_csn_s;
            if (!w_flushed) begin
                r_flush <= r_flush + 1'b1;
            end
            if (w_flushed && w_csn_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    logic       w_rise;
    logic       w_fall;
    logic       w_sel;
    logic       w_desel;
    logic       w_boundary;
    logic       w_reload;
    logic       w_accept;
    logic [7:0] w_next_byte;

    assign w_rise      = w_sck_s & ~r_sck_d;
    assign w_fall      = ~w_sck_s & r_sck_d;
    assign w_sel       = r_armed & r_csn_d & ~w_csn_s;
    assign w_desel     = w_csn_s & ~r_csn_d;
    assign w_boundary  = (r_state == ST_SHIFT) & ~w_desel & w_rise & (r_bit_cnt == 3'd7);
    assign w_reload    = w_boundary | ((r_state == ST_IDLE) & w_sel);
    assign w_accept    = iLoad & ~r_hold_full;
    assign w_next_byte = r_hold_full ? r_hold : FILL;

    // A load in the same cycle as an empty-register reload lands after the reload has chosen FILL.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_taken     <= 1'b0;
            r_under     <= 1'b0;
        end else begin
            r_taken <= w_accept;
            r_under <= w_reload & ~r_hold_full;
            if (w_accept) begin
                r_hold      <= iData;
                r_hold_full <= 1'b1;
            end else if (w_reload && r_hold_full) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_state   <= ST_IDLE;
            r_tx      <= 8'h00;
            r_tx_new  <= 1'b0;
            r_rx      <= 7'h00;
            r_bit_cnt <= 3'd0;
            r_miso    <= 1'b1;
            r_data    <= 8'h00;
            r_avail   <= 1'b0;
        end else begin
            r_avail <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_miso <= 1'b1;
                    if (w_sel) begin
                        r_state   <= ST_SHIFT;
                        r_tx      <= w_next_byte;
                        r_tx_new  <= 1'b0;
                        r_miso    <= w_next_byte[7];
                        r_bit_cnt <= 3'd0;
                    end
                end
                ST_SHIFT: begin
                    if (w_desel) begin
                        r_state   <= ST_IDLE;
                        r_bit_cnt <= 3'd0;
                        r_miso    <= 1'b1;
                    end else if (w_rise) begin
                        r_rx      <= {r_rx[5:0], w_mosi_s};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_boundary) begin
                            r_data   <= {r_rx, w_mosi_s};
                            r_avail  <= 1'b1;
                            r_tx     <= w_next_byte;
                            r_tx_new <= 1'b1;
                        end
                    end else if (w_fall) begin
                        // The fall after a reload presents the fresh MSB instead of shifting.
                        if (r_tx_new) begin
                            r_miso   <= r_tx[7];
                            r_tx_new <= 1'b0;
                        end else begin
                            r_miso <= r_tx[6];
                            r_tx   <= {r_tx[6:0], 1'b1};
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign oMiso   = r_miso;
    assign oMisoEn = (r_state == ST_SHIFT);
    assign oBusy   = (r_state == ST_SHIFT);
    assign oData   = r_data;
    assign oAvail  = r_avail;
    assign oTaken  = r_taken;
    assign oUnder  = r_under;

endmodule
